// File: rtl/defuzz_seq.sv
// rtl/defuzz_seq.sv - handshaked centroid defuzzifier, G = S_wg*SCALE/max(S_w,EPS)
module defuzz_seq #(
  parameter int W     = 16,
  parameter int SCALE = 100,
  parameter int OUT_W = 8,
  parameter int EPS   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     S_w,
  input  logic [W-1:0]     S_wg,
  input  logic             rnd_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] G_out,
  output logic             eps_flag,
  output logic             sat_flag
);

  localparam int CW = W + OUT_W;
  localparam int IW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [W-1:0]     EPS_W   = W'(EPS);
  localparam logic [CW-1:0]    SCALE_C = CW'(SCALE);
  localparam logic [OUT_W-1:0] SCALE_G = OUT_W'(SCALE);
  localparam logic [IW-1:0]    I_TOP   = IW'(OUT_W - 1);

  generate
    if ((64'd1 << OUT_W) <= 64'(SCALE)) begin : g_out_w_check
      $error("defuzz_seq: 2**OUT_W must exceed SCALE");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

  state_t            state, state_nxt;
  logic [W-1:0]      den;
  logic              eps_r;
  logic              rnd_r;
  logic [CW-1:0]     rem;
  logic [OUT_W-1:0]  q;
  logic [IW-1:0]     idx;

  logic [W-1:0]      den_in;
  logic              eps_in;
  logic              sat_in;
  logic [CW-1:0]     den_sh;
  logic              rem_ge;
  logic              round_up;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    eps_in    = (S_w < EPS_W);
    den_in    = eps_in ? EPS_W : S_w;
    sat_in    = (S_wg >= den_in);
    den_sh    = {{OUT_W{1'b0}}, den} << idx;
    rem_ge    = (rem >= den_sh);
    // remainder is below den here, so doubling it cannot overflow CW+1 bits
    round_up  = !rnd_r && ({rem, 1'b0} >= {{(OUT_W + 1){1'b0}}, den});
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = sat_in ? DONE : CALC;
      end
      CALC: begin
        if (idx == '0) state_nxt = ROUND;
      end
      ROUND: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      den      <= '0;
      eps_r    <= 1'b0;
      rnd_r    <= 1'b0;
      rem      <= '0;
      q        <= '0;
      idx      <= '0;
      G_out    <= '0;
      eps_flag <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            den   <= den_in;
            eps_r <= eps_in;
            rnd_r <= rnd_mode;
            q     <= '0;
            idx   <= I_TOP;
            rem   <= {{OUT_W{1'b0}}, S_wg} * SCALE_C;
            // saturation skips the divider and publishes the result immediately
            if (sat_in) begin
              G_out    <= SCALE_G;
              eps_flag <= eps_in;
              sat_flag <= 1'b1;
            end
          end
        end
        CALC: begin
          if (rem_ge) begin
            rem    <= rem - den_sh;
            q[idx] <= 1'b1;
          end
          idx <= idx - 1'b1;
        end
        ROUND: begin
          G_out    <= q + OUT_W'(round_up);
          eps_flag <= eps_r;
          sat_flag <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_defuzz_seq.sv
// tb/tb_defuzz_seq.sv - scoreboard bench for defuzz_seq
module tb_defuzz_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        rnd_mode = 1'b0;
  logic [15:0] S_w = '0;
  logic [15:0] S_wg = '0;
  logic        in_ready, out_valid, eps_flag, sat_flag, out_ready;
  logic [7:0]  G_out;

  logic        ready_dir = 1'b0;
  logic        rnd_rdy = 1'b0;
  bit          rand_ready = 1'b0;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [9:0]  exp_q[$];

  typedef struct {
    logic [15:0] sw;
    logic [15:0] swg;
    logic        rm;
    logic [9:0]  e;
    int          lat;
  } vec_t;

  assign out_ready = rand_ready ? rnd_rdy : ready_dir;

  always #5 clk = ~clk;

  defuzz_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .S_w(S_w), .S_wg(S_wg), .rnd_mode(rnd_mode), .out_valid(out_valid),
    .out_ready(out_ready), .G_out(G_out), .eps_flag(eps_flag), .sat_flag(sat_flag)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // reference: {G, eps, sat}
  function automatic logic [9:0] model(input logic [15:0] sw, input logic [15:0] swg, input logic rm);
    longint den, num, qq, r;
    logic [7:0] g;
    den = (sw == 16'd0) ? 1 : longint'(sw);
    if (longint'(swg) >= den) return {8'd100, (sw == 16'd0), 1'b1};
    num = longint'(swg) * 100;
    qq  = num / den;
    r   = num % den;
    if (!rm && 2 * r >= den) qq++;
    g = qq[7:0];
    return {g, (sw == 16'd0), 1'b0};
  endfunction

  task automatic issue(input logic [15:0] sw, input logic [15:0] swg, input logic rm,
                       input logic [9:0] e, input bit push);
    int n;
    S_w = sw; S_wg = swg; rnd_mode = rm; in_valid = 1'b1; n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
    else if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    S_w = 16'($urandom); S_wg = 16'($urandom); rnd_mode = 1'($urandom);
  endtask

  // k = 1 on the first cycle after the accept edge
  task automatic wait_valid(output int k, output bit ir_seen);
    k = 1; ir_seen = 1'b0;
    @(negedge clk);
    while (!out_valid && k < 50) begin
      if (in_ready) ir_seen = 1'b1;
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rnd_rdy = 1'($urandom_range(0, 1));
    end
  end

  initial begin : monitor
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", {22'd0, G_out, eps_flag, sat_flag}, 32'h3ff);
        else begin
          e = exp_q.pop_front();
          check("result_g_eps_sat", {22'd0, G_out, eps_flag, sat_flag}, {22'd0, e});
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    vec_t vecs[9];
    int   k;
    bit   ir;
    logic [15:0] sw, swg;
    logic        rm;

    vecs = '{
      '{16'd8,      16'd1,      1'b0, {8'd13,  2'b00}, 10},
      '{16'd8,      16'd1,      1'b1, {8'd12,  2'b00}, 10},
      '{16'd3,      16'd1,      1'b0, {8'd33,  2'b00}, 10},
      '{16'd3,      16'd1,      1'b1, {8'd33,  2'b00}, 10},
      '{16'd3,      16'd2,      1'b0, {8'd67,  2'b00}, 10},
      '{16'd3,      16'd2,      1'b1, {8'd66,  2'b00}, 10},
      '{16'd0,      16'd0,      1'b0, {8'd0,   2'b10}, 10},
      '{16'd0,      16'd5,      1'b0, {8'd100, 2'b11}, 1},
      '{16'h7fff,   16'h7fff,   1'b0, {8'd100, 2'b01}, 1}
    };

    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_g_out", G_out, 0);
    check("rst_eps_flag", eps_flag, 0);
    check("rst_sat_flag", sat_flag, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_dir = 1'b1;

    issue(16'h4000, 16'h2000, 1'b0, {8'd50, 2'b00}, 1);
    wait_valid(k, ir);
    check("half_latency", k, 10);
    check("half_in_ready_busy", ir, 0);
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      issue(vecs[i].sw, vecs[i].swg, vecs[i].rm, vecs[i].e, 1);
      wait_valid(k, ir);
      check($sformatf("vec%0d_latency", i), k, vecs[i].lat);
      @(posedge clk);
      #1;
    end

    // backpressure
    ready_dir = 1'b0;
    issue(16'd3, 16'd2, 1'b0, {8'd67, 2'b00}, 1);
    wait_valid(k, ir);
    @(posedge clk);
    #1;
    in_valid = 1'b1; S_w = 16'd8; S_wg = 16'd1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_hold_result", {G_out, eps_flag, sat_flag}, {8'd67, 2'b00});
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ready_dir = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    check("bp_retained_g", G_out, 67);

    // reset in the middle of a divide
    issue(16'h4000, 16'h2000, 1'b0, 10'd0, 0);
    repeat (3) @(posedge clk);
    #2;
    check("calc_in_ready_busy", in_ready, 0);
    rst = 1'b1;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(16'h4000, 16'h1000, 1'b0, {8'd25, 2'b00}, 1);
    wait_valid(k, ir);
    check("post_rst_latency", k, 10);
    @(posedge clk);
    #1;

    // random back-to-back with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      sw = 16'($urandom);
      if (i % 7 == 0) sw = 16'($urandom_range(0, 10));
      case ($urandom_range(0, 3))
        0:       swg = 16'($urandom);
        1:       swg = sw;
        default: swg = (sw == 16'd0) ? 16'd0 : 16'($urandom_range(0, 32'(sw) - 1));
      endcase
      rm = 1'($urandom);
      issue(sw, swg, rm, model(sw, swg, rm), 1);
    end
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("drain_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
